// File: rtl/ram_tp_rr_arbiter.sv
// Round-robin arbiter sharing one two-port bit-masked RAM among NUM_REQ requesters.
// Write and read ports are arbitrated independently; read data is routed back by a one-cycle pending tag.
module ram_tp_rr_arbiter #(
    parameter  int NUM_REQ    = 2,
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               wr_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_data,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_mask,
    output logic [NUM_REQ-1:0]               wr_gnt,
    input  logic [NUM_REQ-1:0]               rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    rd_addr,
    output logic [NUM_REQ-1:0]               rd_gnt,
    output logic [NUM_REQ-1:0]               rd_valid,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             ram_cen,
    output logic                             ram_wen,
    output logic [DATA_WIDTH-1:0]            ram_bwen,
    output logic [ADDR_WIDTH-1:0]            ram_waddr,
    output logic [DATA_WIDTH-1:0]            ram_wdata,
    output logic                             ram_ren,
    output logic [ADDR_WIDTH-1:0]            ram_raddr,
    input  logic [DATA_WIDTH-1:0]            ram_rdata
);

    logic [ID_WIDTH-1:0] wr_ptr;
    logic [ID_WIDTH-1:0] rd_ptr;
    logic [NUM_REQ-1:0]  rd_pend;

    // First requesting index at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic [ID_WIDTH-1:0] ptr);
        logic [NUM_REQ-1:0] g;
        logic               found;
        int                 idx;
        g     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [NUM_REQ-1:0] gnt,
                                                     input logic [ID_WIDTH-1:0] ptr);
        logic [ID_WIDTH-1:0] p;
        p = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) p = ID_WIDTH'((i + 1) % NUM_REQ);
        end
        return p;
    endfunction

    assign wr_gnt = reset ? '0 : rr_pick(wr_req, wr_ptr);
    assign rd_gnt = reset ? '0 : rr_pick(rd_req, rd_ptr);

    always_comb begin
        ram_waddr = '0;
        ram_wdata = '0;
        ram_bwen  = '0;
        ram_raddr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                ram_waddr = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                ram_wdata = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                ram_bwen  = wr_mask[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_gnt[i]) begin
                ram_raddr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign ram_wen = |wr_gnt;
    assign ram_ren = |rd_gnt;
    assign ram_cen = ram_wen | ram_ren;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_pend <= '0;
        end else begin
            wr_ptr  <= next_ptr(wr_gnt, wr_ptr);
            rd_ptr  <= next_ptr(rd_gnt, rd_ptr);
            rd_pend <= rd_gnt;
        end
    end

    // A response already in flight when reset rises is suppressed immediately, not one cycle later.
    assign rd_valid = reset ? '0 : rd_pend;
    assign rd_data  = (|rd_valid) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_tp_rr_arbiter.sv
// Directed bench for ram_tp_rr_arbiter with a behavioural two-port bit-masked RAM attached.
module tb_ram_tp_rr_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   wr_req = '0;
    logic [NR*AW-1:0] wr_addr = '0;
    logic [NR*DW-1:0] wr_data = '0;
    logic [NR*DW-1:0] wr_mask = '0;
    logic [NR-1:0]   wr_gnt;
    logic [NR-1:0]   rd_req = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR-1:0]   rd_gnt;
    logic [NR-1:0]   rd_valid;
    logic [DW-1:0]   rd_data;
    logic            ram_cen, ram_wen, ram_ren;
    logic [DW-1:0]   ram_bwen, ram_wdata;
    logic [AW-1:0]   ram_waddr, ram_raddr;
    logic [DW-1:0]   ram_rdata = '0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ram_tp_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(16)) dut (
        .clock(clock), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_bwen(ram_bwen), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    // Read-before-write RAM: same-cycle read sees old contents.
    logic [DW-1:0] mem [16] = '{default: '0};
    always @(posedge clock) begin
        if (ram_cen && ram_ren) ram_rdata <= mem[ram_raddr];
        if (ram_cen && ram_wen) mem[ram_waddr] <= (mem[ram_waddr] & ~ram_bwen) | (ram_wdata & ram_bwen);
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_wr(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        wr_addr[r*AW +: AW] = a;
        wr_data[r*DW +: DW] = d;
        wr_mask[r*DW +: DW] = m;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        wr_req = '0;
        rd_req = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [NR-1:0] wr_req;
        logic [NR-1:0] rd_req;
        logic [NR-1:0] exp_wg;
        logic [NR-1:0] exp_rg;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [NR-1:0] prev_rg;
        logic [AW-1:0] exp_wa;
        logic [NR-1:0] seq [4];
        logic [DW-1:0] dat_of [NR];

        vecs[0] = '{2'b11, 2'b00, 2'b01, 2'b00};
        vecs[1] = '{2'b11, 2'b00, 2'b10, 2'b00};
        vecs[2] = '{2'b11, 2'b00, 2'b01, 2'b00};
        vecs[3] = '{2'b11, 2'b00, 2'b10, 2'b00};
        vecs[4] = '{2'b10, 2'b11, 2'b10, 2'b01};
        vecs[5] = '{2'b01, 2'b11, 2'b01, 2'b10};
        vecs[6] = '{2'b00, 2'b10, 2'b00, 2'b10};
        vecs[7] = '{2'b10, 2'b01, 2'b10, 2'b01};
        vecs[8] = '{2'b00, 2'b00, 2'b00, 2'b00};
        vecs[9] = '{2'b11, 2'b11, 2'b01, 2'b10};

        // Reset with requests held: nothing may be granted.
        #1;
        wr_req = 2'b11;
        rd_req = 2'b11;
        #4;
        chk("reset_wr_gnt", DW'(wr_gnt), 0);
        chk("reset_rd_gnt", DW'(rd_gnt), 0);
        chk("reset_cen", DW'(ram_cen), 0);
        next_cycle();
        #4;
        chk("reset_rd_valid", DW'(rd_valid), 0);
        next_cycle();
        reset = 1'b0;

        // Arbitration table; masks zero so RAM contents stay untouched.
        set_wr(0, 4'd1, 32'h0, 32'h0);
        set_wr(1, 4'd2, 32'h0, 32'h0);
        rd_addr = {4'd1, 4'd0};
        prev_rg = '0;
        for (int v = 0; v < 10; v++) begin
            wr_req = vecs[v].wr_req;
            rd_req = vecs[v].rd_req;
            #4;
            exp_wa = (vecs[v].exp_wg == 2'b01) ? 4'd1 : (vecs[v].exp_wg == 2'b10) ? 4'd2 : 4'd0;
            chk($sformatf("v%0d_wr_gnt", v), DW'(wr_gnt), DW'(vecs[v].exp_wg));
            chk($sformatf("v%0d_rd_gnt", v), DW'(rd_gnt), DW'(vecs[v].exp_rg));
            chk($sformatf("v%0d_wen", v), DW'(ram_wen), DW'(|vecs[v].exp_wg));
            chk($sformatf("v%0d_ren", v), DW'(ram_ren), DW'(|vecs[v].exp_rg));
            chk($sformatf("v%0d_cen", v), DW'(ram_cen), DW'((|vecs[v].exp_wg) | (|vecs[v].exp_rg)));
            chk($sformatf("v%0d_waddr", v), DW'(ram_waddr), DW'(exp_wa));
            chk($sformatf("v%0d_rd_valid", v), DW'(rd_valid), DW'(prev_rg));
            prev_rg = vecs[v].exp_rg;
            next_cycle();
        end
        wr_req = '0;
        rd_req = '0;
        next_cycle();

        // Requester 0 writes addr 3, requester 1 reads it back the next cycle.
        set_wr(0, 4'd3, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        wr_req = 2'b01;
        #4;
        chk("a_wr_gnt", DW'(wr_gnt), 32'h1);
        chk("a_wdata", ram_wdata, 32'hA5A5_A5A5);
        chk("a_bwen", ram_bwen, 32'hFFFF_FFFF);
        next_cycle();
        wr_req = '0;
        rd_addr[1*AW +: AW] = 4'd3;
        rd_req = 2'b10;
        #4;
        chk("a_rd_gnt", DW'(rd_gnt), 32'h2);
        chk("a_raddr", DW'(ram_raddr), 32'h3);
        next_cycle();
        rd_req = '0;
        #4;
        chk("a_rd_valid", DW'(rd_valid), 32'h2);
        chk("a_rd_data", rd_data, 32'hA5A5_A5A5);
        next_cycle();
        #4;
        chk("a_rd_valid_clr", DW'(rd_valid), 32'h0);
        chk("a_rd_data_clr", rd_data, 32'h0);
        next_cycle();

        // Partial-mask write on top of a full write.
        set_wr(0, 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wr_req = 2'b01;
        next_cycle();
        set_wr(1, 4'd5, 32'h0000_0000, 32'h0000_FF00);
        wr_req = 2'b10;
        #4;
        chk("b_bwen", ram_bwen, 32'h0000_FF00);
        next_cycle();
        wr_req = '0;
        rd_addr[0 +: AW] = 4'd5;
        rd_req = 2'b01;
        next_cycle();
        rd_req = '0;
        #4;
        chk("b_rd_valid", DW'(rd_valid), 32'h1);
        chk("b_rd_data", rd_data, 32'hFFFF_00FF);
        next_cycle();

        // Back-to-back alternating reads from a fresh read pointer.
        do_reset();
        seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        dat_of[0] = 32'hA5A5_A5A5;
        dat_of[1] = 32'hFFFF_00FF;
        rd_addr = {4'd5, 4'd3};
        rd_req  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #4;
            chk($sformatf("c%0d_rd_gnt", k), DW'(rd_gnt), DW'(seq[k]));
            if (k > 0) begin
                chk($sformatf("c%0d_rd_valid", k), DW'(rd_valid), DW'(seq[k-1]));
                chk($sformatf("c%0d_rd_data", k), rd_data, dat_of[seq[k-1] == 2'b01 ? 0 : 1]);
            end
            next_cycle();
        end
        rd_req = '0;
        #4;
        chk("c4_rd_valid", DW'(rd_valid), 32'h2);
        chk("c4_rd_data", rd_data, 32'hFFFF_00FF);
        next_cycle();

        // Same-cycle write and read of addr 7: old data first, new data on the next read.
        set_wr(0, 4'd7, 32'h0000_1234, 32'hFFFF_FFFF);
        wr_req = 2'b01;
        rd_addr = {4'd7, 4'd7};
        rd_req = 2'b10;
        #4;
        chk("d_wr_gnt", DW'(wr_gnt), 32'h1);
        chk("d_rd_gnt", DW'(rd_gnt), 32'h2);
        next_cycle();
        wr_req = '0;
        rd_req = 2'b01;
        #4;
        chk("d_old_valid", DW'(rd_valid), 32'h2);
        chk("d_old_data", rd_data, 32'h0);
        chk("d_rd_gnt2", DW'(rd_gnt), 32'h1);
        next_cycle();
        rd_req = '0;
        #4;
        chk("d_new_valid", DW'(rd_valid), 32'h1);
        chk("d_new_data", rd_data, 32'h0000_1234);
        next_cycle();

        // Reset right after a read grant: response dropped, pointers restart.
        wr_req = 2'b01;
        rd_addr[0 +: AW] = 4'd3;
        rd_req = 2'b01;
        #4;
        chk("e_rd_gnt", DW'(rd_gnt), 32'h1);
        chk("e_wr_gnt", DW'(wr_gnt), 32'h1);
        next_cycle();
        reset  = 1'b1;
        wr_req = 2'b11;
        rd_req = 2'b11;
        #4;
        chk("e_rst_rd_valid", DW'(rd_valid), 32'h0);
        chk("e_rst_rd_data", rd_data, 32'h0);
        chk("e_rst_wr_gnt", DW'(wr_gnt), 32'h0);
        chk("e_rst_rd_gnt", DW'(rd_gnt), 32'h0);
        chk("e_rst_cen", DW'(ram_cen), 32'h0);
        next_cycle();
        #4;
        chk("e_rst_rd_valid2", DW'(rd_valid), 32'h0);
        next_cycle();
        reset = 1'b0;
        rd_req = '0;
        set_wr(0, 4'd9, 32'h0, 32'h0);
        set_wr(1, 4'd9, 32'h0, 32'h0);
        #4;
        chk("e_post_wr_gnt", DW'(wr_gnt), 32'h1);
        chk("e_post_rd_valid", DW'(rd_valid), 32'h0);
        next_cycle();
        #4;
        chk("e_post_wr_gnt2", DW'(wr_gnt), 32'h2);
        wr_req = '0;
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
